// File: rtl/dht11_reader.sv
// DHT11 single-wire protocol master.
// Issues the host start pulse, follows the sensor response, decodes 40 data
// bits by high-pulse width and checks the checksum. Good frames are presented
// on the byte outputs; bad frames and stalled edges raise one-cycle error pulses.
module dht11_reader #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int START_LOW_US = 18_000,
    parameter int BIT1_THR_US  = 40,
    parameter int TIMEOUT_US   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inout  wire        dht_io,
    output logic [7:0] humi_integral,
    output logic [7:0] humi_decimal,
    output logic [7:0] temp_integral,
    output logic [7:0] temp_decimal,
    output logic [7:0] parity,
    output logic       busy,
    output logic       valid,
    output logic       checksum_err,
    output logic       timeout_err
);

    // Clock cycles per microsecond; a divisor of 1 gives a tick every cycle.
    localparam int TICK_DIV = CLK_HZ / 1_000_000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START_LO,
        START_REL,
        RESP_LO,
        RESP_HI,
        BIT_LO,
        BIT_HI,
        CHECK
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic             tick;
    logic [15:0]      us_cnt_reg;
    logic [2:0]       sync_reg;
    logic             pin_cur;
    logic             pin_prev;
    logic             pin_rise;
    logic             pin_fall;
    logic             drive_reg;
    logic [5:0]       bit_idx_reg;
    logic [38:0]      shreg_reg;
    logic [16:0]      hi_elapsed;
    logic             bit_val;
    logic [39:0]      word_next;
    logic [7:0]       rx_byte [0:4];
    logic [7:0]       sum;
    logic             sum_ok;
    logic             shift_en;
    logic             bit_clear;
    logic             last_bit;
    logic             timeout_hit;

    // Open-drain pin: only ever pulls low, otherwise released to the pull-up.
    assign dht_io = drive_reg ? 1'b0 : 1'bz;
    assign busy   = (state_reg != IDLE);

    // Microsecond prescaler, free running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_reg <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    assign tick = (pre_cnt_reg == PRE_W'(TICK_DIV - 1));

    // Two-flop synchronizer plus one history stage for edge detection.
    // Resets to the idle-high line level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], dht_io};
        end
    end

    assign pin_cur  = sync_reg[1];
    assign pin_prev = sync_reg[2];
    assign pin_rise = pin_cur & ~pin_prev;
    assign pin_fall = ~pin_cur & pin_prev;

    // Microseconds spent in the current state; restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            us_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            us_cnt_reg <= '0;
        end else if (tick && (us_cnt_reg != 16'hFFFF)) begin
            us_cnt_reg <= us_cnt_reg + 16'd1;
        end
    end

    // The counter lags the elapsed high time by the tick landing in the
    // detection cycle itself, so that tick is folded in before comparing.
    assign hi_elapsed = {1'b0, us_cnt_reg} + 17'(tick);
    assign bit_val    = (hi_elapsed > 17'(BIT1_THR_US));
    assign word_next  = {shreg_reg, bit_val};

    // Byte view of the frame including the bit being shifted in now.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_bytes
            assign rx_byte[gi] = word_next[39 - 8*gi -: 8];
        end
    endgenerate

    assign sum    = rx_byte[0] + rx_byte[1] + rx_byte[2] + rx_byte[3];
    assign sum_ok = (sum == rx_byte[4]);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the edge-wait states share one timeout.
    always_comb begin
        state_next  = state_reg;
        shift_en    = 1'b0;
        bit_clear   = 1'b0;
        last_bit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = START_LO;
                end
            end
            START_LO: begin
                if (tick && (us_cnt_reg == 16'(START_LOW_US - 1))) begin
                    state_next = START_REL;
                end
            end
            START_REL: begin
                // The synced pin still shows our own low for a few cycles
                // after release, so wait for a genuine falling edge.
                if (us_cnt_reg >= 16'(TIMEOUT_US)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (pin_fall) begin
                    state_next = RESP_LO;
                end
            end
            RESP_LO: begin
                if (us_cnt_reg >= 16'(TIMEOUT_US)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (pin_rise) begin
                    state_next = RESP_HI;
                end
            end
            RESP_HI: begin
                if (us_cnt_reg >= 16'(TIMEOUT_US)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (pin_fall) begin
                    bit_clear  = 1'b1;
                    state_next = BIT_LO;
                end
            end
            BIT_LO: begin
                if (us_cnt_reg >= 16'(TIMEOUT_US)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (pin_rise) begin
                    state_next = BIT_HI;
                end
            end
            BIT_HI: begin
                if (us_cnt_reg >= 16'(TIMEOUT_US)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (pin_fall) begin
                    shift_en = 1'b1;
                    if (bit_idx_reg == 6'd39) begin
                        last_bit   = 1'b1;
                        state_next = CHECK;
                    end else begin
                        state_next = BIT_LO;
                    end
                end
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin driver: registered so the open-drain enable never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drive_reg <= 1'b0;
        end else begin
            drive_reg <= (state_next == START_LO);
        end
    end

    // Bit index and MSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx_reg <= '0;
            shreg_reg   <= '0;
        end else if (bit_clear) begin
            bit_idx_reg <= '0;
        end else if (shift_en) begin
            bit_idx_reg <= bit_idx_reg + 6'd1;
            shreg_reg   <= word_next[38:0];
        end
    end

    // Result registers: checksum evaluated as the last bit lands, so the
    // pulses are visible during CHECK; bytes load only on a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            humi_integral <= '0;
            humi_decimal  <= '0;
            temp_integral <= '0;
            temp_decimal  <= '0;
            parity        <= '0;
            valid         <= 1'b0;
            checksum_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            valid        <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= timeout_hit;
            if (last_bit) begin
                if (sum_ok) begin
                    valid         <= 1'b1;
                    humi_integral <= rx_byte[0];
                    humi_decimal  <= rx_byte[1];
                    temp_integral <= rx_byte[2];
                    temp_decimal  <= rx_byte[3];
                    parity        <= rx_byte[4];
                end else begin
                    checksum_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a behavioural DHT11 sensor on the pin.
// Runs at 1 MHz so one clock equals one microsecond.
module tb_dht11_reader;

    localparam int CLK_HZ       = 1_000_000;
    localparam int START_LOW_US = 20;
    localparam int BIT1_THR_US  = 40;
    localparam int TIMEOUT_US   = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sensor_low;
    wire        dht_io;
    logic [7:0] humi_integral;
    logic [7:0] humi_decimal;
    logic [7:0] temp_integral;
    logic [7:0] temp_decimal;
    logic [7:0] parity;
    logic       busy;
    logic       valid;
    logic       checksum_err;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_cerr  = 0;
    int n_tout  = 0;

    always #5 clk = ~clk;

    pullup (dht_io);
    assign dht_io = sensor_low ? 1'b0 : 1'bz;

    dht11_reader #(
        .CLK_HZ      (CLK_HZ),
        .START_LOW_US(START_LOW_US),
        .BIT1_THR_US (BIT1_THR_US),
        .TIMEOUT_US  (TIMEOUT_US)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start),
        .dht_io       (dht_io),
        .humi_integral(humi_integral),
        .humi_decimal (humi_decimal),
        .temp_integral(temp_integral),
        .temp_decimal (temp_decimal),
        .parity       (parity),
        .busy         (busy),
        .valid        (valid),
        .checksum_err (checksum_err),
        .timeout_err  (timeout_err)
    );

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (valid)        n_valid++;
        if (checksum_err) n_cerr++;
        if (timeout_err)  n_tout++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // All pin/stimulus tasks run in the posedge+1 phase.
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pin(input logic low, input int n);
        sensor_low = low;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pin(input logic lvl, input int bound, input string tag);
        int k;
        k = 0;
        while (dht_io !== lvl && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 64'(dht_io), 64'(lvl));
    endtask

    // Sensor answer; returns right after starting the trailing low that
    // forms the 40th falling edge.
    task automatic sensor_send(input logic [39:0] word, input int w0, input int w1);
        wait_pin(1'b0, 50, "host_low");
        wait_pin(1'b1, 100, "host_release");
        pin(1'b0, 20);
        pin(1'b1, 80);
        pin(1'b0, 80);
        for (int i = 39; i >= 0; i--) begin
            pin(1'b1, 50);
            pin(1'b0, word[i] ? w1 : w0);
        end
        sensor_low = 1'b1;
    endtask

    task automatic finish_tail();
        pin(1'b1, 48);
        pin(1'b0, 10);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int c0;
        int t0;
        int cnt;

        rst_n      = 1'b0;
        start      = 1'b0;
        sensor_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bytes", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity}, 64'd0);
        check("rst_flags", {busy, valid, checksum_err, timeout_err}, 64'd0);
        check("rst_pin", 64'(dht_io), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: reset while the host start low is being driven.
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_drive", 64'(dht_io), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_rst_pin", 64'(dht_io), 64'd1);
        check("t1_rst_busy", 64'(busy), 64'd0);
        check("t1_rst_bytes", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t1_stay_idle", {busy, dht_io}, 64'b01);

        // Test 2: good frame, typical 26/70 us widths, valid latency.
        v0 = n_valid;
        c0 = n_cerr;
        pulse_start();
        sensor_send(40'h35_00_18_05_52, 26, 70);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_valid_early", 64'(valid), 64'd0);
        @(negedge clk);
        check("t2_valid_lat", 64'(valid), 64'd1);
        finish_tail();
        wait_idle("t2_idle");
        check("t2_n_valid", 64'(n_valid - v0), 64'd1);
        check("t2_n_cerr", 64'(n_cerr - c0), 64'd0);
        check("t2_bytes", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity},
              64'h35_00_18_05_52);

        // Test 3: checksum off by one, outputs hold.
        v0 = n_valid;
        c0 = n_cerr;
        pulse_start();
        sensor_send(40'h35_00_18_05_53, 26, 70);
        finish_tail();
        wait_idle("t3_idle");
        check("t3_n_cerr", 64'(n_cerr - c0), 64'd1);
        check("t3_n_valid", 64'(n_valid - v0), 64'd0);
        check("t3_hold", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity},
              64'h35_00_18_05_52);

        // Test 4: silent sensor. Counter reaches 255 us after release;
        // the pulse is registered on the following clock.
        t0 = n_tout;
        pulse_start();
        wait_pin(1'b0, 50, "t4_host_low");
        cnt = 0;
        while (dht_io !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_tout_time", 64'(cnt), 64'(TIMEOUT_US + 1));
        check("t4_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("t4_n_tout", 64'(n_tout - t0), 64'd1);
        check("t4_hold", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity},
              64'h35_00_18_05_52);

        // Test 5: threshold edge widths 40 us -> 0, 41 us -> 1.
        v0 = n_valid;
        pulse_start();
        sensor_send(40'h20_0A_15_03_42, 40, 41);
        finish_tail();
        wait_idle("t5_idle");
        check("t5_n_valid", 64'(n_valid - v0), 64'd1);
        check("t5_bytes", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity},
              64'h20_0A_15_03_42);

        // Test 6: checksum wraps mod 256; second start while busy is dropped.
        v0 = n_valid;
        c0 = n_cerr;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        pulse_start();
        sensor_send(40'hFF_01_00_00_00, 26, 70);
        finish_tail();
        wait_idle("t6_idle");
        check("t6_bytes", {humi_integral, humi_decimal, temp_integral, temp_decimal, parity},
              64'hFF_01_00_00_00);
        repeat (50) @(posedge clk);
        #1;
        check("t6_no_requeue", {busy, dht_io}, 64'b01);
        check("t6_n_valid", 64'(n_valid - v0), 64'd1);
        check("t6_n_cerr", 64'(n_cerr - c0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
